pixel_sink: RTL
===============

PIXEL_SINK -- requirements
Module: pixel_sink

Interface
REQ-001 Parameter WIDTH, default 160, screen width in pixels.
REQ-002 Parameter HEIGHT, default 120, screen height in pixels.
REQ-003 Parameter DEPTH, default 4, input FIFO entries (power of two, at least 2).
REQ-004 clk  in  1  sole clock, all state updates on the rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 plot  in  1  pixel-valid strobe from a drawer.
REQ-007 x_in  in  8  pixel column.
REQ-008 y_in  in  7  pixel row.
REQ-009 c_in  in  3  pixel colour.
REQ-010 ready  out  1  high when the FIFO can accept a pixel this cycle.
REQ-011 mem_busy  in  1  framebuffer write port unavailable (scan-out has priority).
REQ-012 mem_we  out  1  framebuffer write enable, one cycle per pixel.
REQ-013 mem_addr  out  15  framebuffer address, y*WIDTH+x.
REQ-014 mem_data  out  3  framebuffer colour.
REQ-015 pix_count  out  15  pixels written since reset or clear; saturates at 32767.
REQ-016 oob_count  out  8  out-of-bounds pixels dropped; saturates at 255.
REQ-017 overflow  out  1  sticky: plot seen while ready low.
REQ-018 clear  in  1  synchronous clear of pix_count, oob_count and overflow.

Function
REQ-019 Push: plot && ready at an edge writes {x_in,y_in,c_in} into the FIFO.
REQ-020 ready = FIFO not full, decided from registered state only; a push is refused when full even if a pop occurs in the same cycle.
REQ-021 plot while ready is low: pixel discarded, overflow set to 1.
REQ-022 Pop: FIFO not empty && !mem_busy at an edge removes the head entry.
REQ-023 A popped entry with x<WIDTH and y<HEIGHT loads the output register; mem_we is high for exactly the next cycle.
REQ-024 A popped entry with x>=WIDTH or y>=HEIGHT produces no write and increments oob_count.
REQ-025 mem_addr = y*WIDTH + x, computed at full 15-bit width with no truncation; for WIDTH=160, implemented as (y<<7)+(y<<5)+x.
REQ-026 Latency: for a pixel pushed at edge N into an empty FIFO with mem_busy low, mem_we is high in the cycle following edge N+1.
REQ-027 Pixels are written in push order; none are duplicated or reordered.
REQ-028 mem_busy high: no pop occurs and mem_we is 0 in the following cycle; FIFO contents are held.
REQ-029 pix_count increments once per asserted mem_we.
REQ-030 Simultaneous push and pop when not full: both take effect; occupancy is unchanged.
REQ-031 clear and an increment in the same cycle: clear wins.
REQ-032 Read and write pointers wrap modulo DEPTH; occupancy is tracked with a DEPTH+1-valued counter.

Reset
REQ-033 While resetn is low: FIFO empty, ready=1, mem_we=0, mem_addr=0, mem_data=0, pix_count=0, oob_count=0, overflow=0.
REQ-034 Reset asserted mid-stream discards all queued pixels and suppresses any pending mem_we immediately.
REQ-035 The first push is accepted on the first rising edge after resetn deasserts.

Structure
REQ-036 Shared package holds SCREEN_W=160, SCREEN_H=120, the coordinate widths 8/7, the colour width 3 and the address width 15.
REQ-037 One sub-module, pixel_fifo (DEPTH x 18-bit synchronous FIFO with full/empty outputs); address, bounds-check and counter logic stay in pixel_sink.

Verification
REQ-038 Single pixel: push (x=5, y=2, c=3'b101), mem_busy=0 -> mem_we for one cycle at edge N+2, mem_addr=325, mem_data=5, pix_count=1.
REQ-039 Corners: push (0,0,1) then (159,119,7) -> addresses 0 and 19199 in order; pix_count=2.
REQ-040 Out of bounds: push (160,0,2) and (0,120,2) -> no mem_we; oob_count=2; pix_count unchanged.
REQ-041 Backpressure: mem_busy=1, push 5 pixels on consecutive cycles -> ready falls after 4, 5th pixel dropped, overflow=1; release mem_busy -> exactly 4 writes, in order.
REQ-042 Reset mid-stream: 3 pixels queued, pulse resetn low -> mem_we=0 immediately, no further writes, all counters 0, ready=1.
REQ-043 Full-screen stream: 19200 in-range pixels with random mem_busy -> every address 0..19199 written exactly once; pix_count=19200; overflow=0 when plot honours ready.

Source files
------------

// File: rtl/pixel_sink_pkg.sv
// Shared screen geometry, field widths and the packed pixel record for the
// pixel sink and its FIFO.
package pixel_sink_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 3;
  localparam int ADDR_W   = 15;
  localparam int OOB_W    = 8;
  localparam int PIX_W    = X_W + Y_W + C_W;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } pixel_t;
endpackage

// File: rtl/pixel_fifo.sv
// DEPTH x W synchronous FIFO with a combinational head read.
// Push is ignored when full and pop is ignored when empty.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural overflow
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/pixel_sink.sv
// Buffers drawer pixels, drops off-screen ones, and issues one framebuffer
// write per in-range pixel whenever the write port is free.
module pixel_sink
  import pixel_sink_pkg::*;
#(
  parameter int WIDTH  = SCREEN_W,
  parameter int HEIGHT = SCREEN_H,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              plot,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  input  logic [C_W-1:0]    c_in,
  output logic              ready,
  input  logic              mem_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [C_W-1:0]    mem_data,
  output logic [ADDR_W-1:0] pix_count,
  output logic [OOB_W-1:0]  oob_count,
  output logic              overflow,
  input  logic              clear
);
  pixel_t              in_px, head;
  logic                full, empty, pop, in_range;
  logic [ADDR_W-1:0]   addr;

  assign in_px = '{x: x_in, y: y_in, c: c_in};
  assign ready = !full;
  assign pop   = !empty && !mem_busy;

  pixel_fifo #(.DEPTH(DEPTH), .W(PIX_W)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (plot),
    .pop    (pop),
    .wdata  (in_px),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  assign in_range = (int'(head.x) < WIDTH) && (int'(head.y) < HEIGHT);

  generate
    if (WIDTH == 160) begin : g_shift
      // y*160 = y*128 + y*32
      assign addr = (ADDR_W'(head.y) << 7) + (ADDR_W'(head.y) << 5) + ADDR_W'(head.x);
    end else begin : g_mul
      assign addr = ADDR_W'(int'(head.y) * WIDTH + int'(head.x));
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_we <= pop && in_range;
      if (pop && in_range) begin
        mem_addr <= addr;
        mem_data <= head.c;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_count <= '0;
      oob_count <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      pix_count <= '0;
      oob_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (mem_we && pix_count != '1)         pix_count <= pix_count + ADDR_W'(1);
      if (pop && !in_range && oob_count != '1) oob_count <= oob_count + OOB_W'(1);
      if (plot && !ready)                    overflow  <= 1'b1;
    end
  end
endmodule
